fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_ctrl_pkg.sv | 22 ++
 rtl/fft_seq_ctrl_if.sv | 33 +++
 rtl/fft_tag_pipe.sv | 29 ++
 rtl/fft_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and frame-geometry helpers for the streaming FFT sequencing controller.
package fft_ctrl_pkg;

    localparam int DEF_N   = 32;
    localparam int DEF_LAT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Four samples enter per clock, so a frame spans N/4 cycles.
    function automatic int frame_of(input int n);
        return n / 4;
    endfunction

    function automatic int cw_of(input int n);
        return $clog2(n / 4);
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Handshake, datapath-control and twiddle-address bundle between the FFT controller and its environment.
interface fft_seq_ctrl_if
    import fft_ctrl_pkg::*;
#(
    parameter int CW = cw_of(DEF_N)
);
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eof;
    logic          dp_en;
    logic          dp_zero;
    logic          bf_ctrl;
    logic          busy;
    logic [CW-1:0] coeff_addr0;
    logic [CW-1:0] coeff_addr1;

    modport master (
        input  in_valid, in_last, out_ready,
        output in_ready, out_valid, out_sof, out_eof,
               dp_en, dp_zero, bf_ctrl, busy, coeff_addr0, coeff_addr1
    );

    modport slave (
        output in_valid, in_last, out_ready,
        input  in_ready, out_valid, out_sof, out_eof,
               dp_en, dp_zero, bf_ctrl, busy, coeff_addr0, coeff_addr1
    );

endinterface

// File: rtl/fft_tag_pipe.sv
// Enable-shifted one-bit valid-tag delay line that tracks real samples through the datapath.
module fft_tag_pipe #(
    parameter int DEPTH = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_tag,
    output logic o_tag,
    output logic o_empty
);

    logic [DEPTH-1:0] r_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= '0;
        end else if (i_en) begin
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_tag   = r_tag[DEPTH-1];
    assign o_empty = ~|r_tag;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a 4-sample/cycle pipelined FFT: frame counting, pad/drain control,
// twiddle addressing and output framing with downstream backpressure.
module fft_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic           clk,
    input  logic           rst,
    fft_seq_ctrl_if.master bus
);

    localparam int            FRAME    = frame_of(N);
    localparam int            CW       = cw_of(N);
    localparam logic [CW-1:0] LAST_CYC = CW'(FRAME - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rel;
    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] r_out_cnt;
    logic          r_pad;
    logic          r_out_valid;

    logic          w_stall;
    logic          w_out_fire;
    logic          w_accept;
    logic          w_in_ready;
    logic          w_dp_en;
    logic          w_dp_zero;
    logic          w_busy;
    logic          w_tag_in;
    logic          w_pipe_tag;
    logic          w_pipe_empty;
    logic          w_flush_done;

    // Reset assertion is immediate; release becomes visible only after one clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rel <= 1'b0;
        end else begin
            r_rel <= 1'b1;
        end
    end

    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign w_out_fire   = r_out_valid & bus.out_ready;
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_flush_done = w_pipe_empty & ~r_pad & (~r_out_valid | bus.out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && bus.in_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_flush_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // in_ready depends only on state, release and out_ready, never on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        w_dp_en    = 1'b0;
        w_dp_zero  = 1'b0;
        w_busy     = 1'b0;
        w_tag_in   = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                w_in_ready = r_rel & ~w_stall;
                w_dp_en    = bus.in_valid & r_rel & ~w_stall;
                w_tag_in   = bus.in_valid & r_rel & ~w_stall;
                w_busy     = (r_state == ST_RUN);
            end
            ST_FLUSH: begin
                w_dp_en   = ~w_stall;
                w_dp_zero = 1'b1;
                w_busy    = 1'b1;
                w_tag_in  = r_pad;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // r_pad marks zero-filled cycles that still belong to the final frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt <= '0;
            r_pad     <= 1'b0;
        end else if (r_state == ST_FLUSH && w_flush_done) begin
            r_cyc_cnt <= '0;
            r_pad     <= 1'b0;
        end else if (w_dp_en) begin
            r_cyc_cnt <= (r_cyc_cnt == LAST_CYC) ? '0 : r_cyc_cnt + CW'(1);
            if (w_accept && bus.in_last) begin
                r_pad <= (r_cyc_cnt != LAST_CYC);
            end else if (r_cyc_cnt == LAST_CYC) begin
                r_pad <= 1'b0;
            end
        end
    end

    fft_tag_pipe #(
        .DEPTH (LAT - 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_dp_en),
        .i_tag   (w_tag_in),
        .o_tag   (w_pipe_tag),
        .o_empty (w_pipe_empty)
    );

    // out_valid is the last stage of the tag delay, so total latency is LAT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
        end else begin
            if (w_dp_en) begin
                r_out_valid <= w_pipe_tag;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire) begin
                r_out_cnt <= (r_out_cnt == LAST_CYC) ? '0 : r_out_cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.dp_en       = w_dp_en;
    assign bus.dp_zero     = w_dp_zero;
    assign bus.busy        = w_busy;
    assign bus.bf_ctrl     = r_cyc_cnt[CW-1];
    assign bus.coeff_addr0 = r_cyc_cnt;
    assign bus.coeff_addr1 = r_out_cnt;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_sof     = r_out_valid & (r_out_cnt == '0);
    assign bus.out_eof     = r_out_valid & (r_out_cnt == LAST_CYC);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with N=32, LAT=16 (FRAME=8): a per-cycle vector table plus
// hand-written stall, pad, alternating, two-frame and mid-flush reset sequences.
module tb_fft_seq_ctrl;

    localparam int N   = 32;
    localparam int LAT = 16;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fft_seq_ctrl_if #(.CW(CW)) bus ();

    fft_seq_ctrl #(.N(N), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic iv, il, rdy;
        logic e_ir, e_en, e_zero, e_bf, e_ov, e_sof, e_eof, e_busy;
        int   e_a0, e_a1;
    } vec_t;

    vec_t tbl [26];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   hs, zc, sof_c, eof_c, sof_n, eof_n;
    int   sof_at [2];
    int   eof_at [2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic l, input logic r);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with rst low; leaves the bench at the start of cycle 0.
    task automatic do_release();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("release in_ready", int'(bus.in_ready), 0);
        tick();
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (bus.busy && k < max_cyc) begin
            tick();
            k++;
        end
        chk("wait_idle busy", int'(bus.busy), 0);
    endtask

    task automatic run_table(input string pfx);
        for (int c = 0; c < 26; c++) begin
            drive(tbl[c].iv, tbl[c].il, tbl[c].rdy);
            @(negedge clk);
            chk($sformatf("%s[%0d] in_ready", pfx, c), int'(bus.in_ready), int'(tbl[c].e_ir));
            chk($sformatf("%s[%0d] dp_en", pfx, c), int'(bus.dp_en), int'(tbl[c].e_en));
            chk($sformatf("%s[%0d] dp_zero", pfx, c), int'(bus.dp_zero), int'(tbl[c].e_zero));
            chk($sformatf("%s[%0d] bf_ctrl", pfx, c), int'(bus.bf_ctrl), int'(tbl[c].e_bf));
            chk($sformatf("%s[%0d] coeff_addr0", pfx, c), int'(bus.coeff_addr0), tbl[c].e_a0);
            chk($sformatf("%s[%0d] out_valid", pfx, c), int'(bus.out_valid), int'(tbl[c].e_ov));
            chk($sformatf("%s[%0d] out_sof", pfx, c), int'(bus.out_sof), int'(tbl[c].e_sof));
            chk($sformatf("%s[%0d] out_eof", pfx, c), int'(bus.out_eof), int'(tbl[c].e_eof));
            chk($sformatf("%s[%0d] coeff_addr1", pfx, c), int'(bus.coeff_addr1), tbl[c].e_a1);
            chk($sformatf("%s[%0d] busy", pfx, c), int'(bus.busy), int'(tbl[c].e_busy));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // One 8-input frame, in_last on the 8th, sink always ready.
        for (int c = 0; c < 26; c++) begin
            tbl[c].iv     = (c < 8);
            tbl[c].il     = (c == 7);
            tbl[c].rdy    = 1'b1;
            tbl[c].e_ir   = (c < 8) || (c >= 24);
            tbl[c].e_en   = (c < 24);
            tbl[c].e_zero = (c >= 8) && (c < 24);
            tbl[c].e_a0   = (c < 24) ? (c % 8) : 0;
            tbl[c].e_bf   = (tbl[c].e_a0 >= 4);
            tbl[c].e_ov   = (c >= 16) && (c < 24);
            tbl[c].e_sof  = (c == 16);
            tbl[c].e_eof  = (c == 23);
            tbl[c].e_a1   = (c >= 16 && c < 24) ? (c - 16) : 0;
            tbl[c].e_busy = (c >= 1) && (c < 24);
        end

        drive(1'b1, 1'b0, 1'b1);
        #12;
        chk("rst in_ready", int'(bus.in_ready), 0);
        chk("rst dp_en", int'(bus.dp_en), 0);
        chk("rst dp_zero", int'(bus.dp_zero), 0);
        chk("rst bf_ctrl", int'(bus.bf_ctrl), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst out_sof", int'(bus.out_sof), 0);
        chk("rst out_eof", int'(bus.out_eof), 0);
        chk("rst coeff_addr0", int'(bus.coeff_addr0), 0);
        chk("rst coeff_addr1", int'(bus.coeff_addr1), 0);
        tick();
        do_release();
        run_table("frame");

        // Sink stalls for 3 cycles while the frame is being output.
        hs = 0; eof_c = -1; sof_c = -1;
        for (int c = 0; c < 30; c++) begin
            drive(c < 8, c == 7, !(c >= 18 && c <= 20));
            @(negedge clk);
            if (c >= 18 && c <= 20) begin
                chk($sformatf("stall[%0d] out_valid", c), int'(bus.out_valid), 1);
                chk($sformatf("stall[%0d] dp_en", c), int'(bus.dp_en), 0);
                chk($sformatf("stall[%0d] in_ready", c), int'(bus.in_ready), 0);
                chk($sformatf("stall[%0d] coeff_addr0", c), int'(bus.coeff_addr0), 2);
                chk($sformatf("stall[%0d] bf_ctrl", c), int'(bus.bf_ctrl), 0);
            end
            if (bus.out_valid && bus.out_ready) hs++;
            if (bus.out_sof && bus.out_ready) sof_c = c;
            if (bus.out_eof && bus.out_ready) eof_c = c;
            tick();
        end
        chk("stall handshakes", hs, 8);
        chk("stall sof cycle", sof_c, 16);
        chk("stall eof cycle", eof_c, 26);
        chk("stall busy after", int'(bus.busy), 0);

        // Short stream: in_last on the 3rd input forces 5 pad cycles.
        hs = 0; zc = 0; sof_c = -1; eof_c = -1;
        for (int c = 0; c < 30; c++) begin
            drive(c < 3, c == 2, 1'b1);
            @(negedge clk);
            if (bus.dp_zero) zc++;
            if (bus.out_valid && bus.out_ready) hs++;
            if (bus.out_sof) sof_c = c;
            if (bus.out_eof) eof_c = c;
            tick();
        end
        chk("pad dp_zero cycles", zc, 21);
        chk("pad handshakes", hs, 8);
        chk("pad sof cycle", sof_c, 16);
        chk("pad eof cycle", eof_c, 23);
        chk("pad busy after", int'(bus.busy), 0);

        // in_valid alternates: the counter advances only on accepted cycles.
        for (int c = 0; c < 15; c++) begin
            drive((c % 2) == 0, c == 14, 1'b1);
            @(negedge clk);
            chk($sformatf("alt[%0d] dp_en", c), int'(bus.dp_en), int'((c % 2) == 0));
            if ((c % 2) == 0) begin
                chk($sformatf("alt[%0d] coeff_addr0", c), int'(bus.coeff_addr0), (c / 2) % 8);
                chk($sformatf("alt[%0d] bf_ctrl", c), int'(bus.bf_ctrl), int'(((c / 2) % 8) >= 4));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1);
        wait_idle(80);
        tick();

        // Two back-to-back frames in one stream.
        sof_n = 0; eof_n = 0;
        for (int c = 0; c < 36; c++) begin
            drive(c < 16, c == 15, 1'b1);
            @(negedge clk);
            if (bus.out_sof) begin
                if (sof_n < 2) sof_at[sof_n] = c;
                sof_n++;
            end
            if (bus.out_eof) begin
                if (eof_n < 2) eof_at[eof_n] = c;
                eof_n++;
            end
            if (c == 23) chk("two coeff_addr1 at 23", int'(bus.coeff_addr1), 7);
            if (c == 24) chk("two coeff_addr1 at 24", int'(bus.coeff_addr1), 0);
            tick();
        end
        chk("two sof count", sof_n, 2);
        chk("two eof count", eof_n, 2);
        if (sof_n >= 2) begin
            chk("two sof0", sof_at[0], 16);
            chk("two sof1", sof_at[1], 24);
        end
        if (eof_n >= 2) begin
            chk("two eof0", eof_at[0], 23);
            chk("two eof1", eof_at[1], 31);
        end
        chk("two busy after", int'(bus.busy), 0);

        // Asynchronous reset in the middle of FLUSH while output is active.
        for (int c = 0; c < 18; c++) begin
            drive(c < 8, c == 7, 1'b1);
            tick();
        end
        chk("pre-reset out_valid", int'(bus.out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst out_valid", int'(bus.out_valid), 0);
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst coeff_addr0", int'(bus.coeff_addr0), 0);
        chk("midrst coeff_addr1", int'(bus.coeff_addr1), 0);
        chk("midrst dp_zero", int'(bus.dp_zero), 0);
        chk("midrst in_ready", int'(bus.in_ready), 0);
        tick();
        chk("midrst hold busy", int'(bus.busy), 0);
        do_release();
        run_table("rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
